// File: rtl/usb_rx_ctrl.sv
// ============================================================================
// Module   : usb_rx_ctrl
// Brief    : USB full-speed receiver control unit. Validates SYNC, strobes
//            payload bytes into the RX FIFO, counts them, flags errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_rx_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         MAX_BYTES = 64,
  parameter int         CNT_W     = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             d_edge,
  input  logic             eop,
  input  logic             shift_enable,
  input  logic             byte_received,
  input  logic [7:0]       rcv_data,
  output logic             rcving,
  output logic             enable_timer,
  output logic             w_enable,
  output logic             r_error,
  output logic [CNT_W-1:0] byte_cnt
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SYNC_WAIT = 4'd1,
    SYNC_CHK  = 4'd2,
    RCV_BYTE  = 4'd3,
    STORE     = 4'd4,
    EOP_CHK   = 4'd5,
    EOP_DONE  = 4'd6,
    ERR_EOP   = 4'd7,
    ERR_WAIT  = 4'd8,
    ERR_IDLE  = 4'd9
  } state_t;

  state_t           state_q, state_d;
  logic             rcving_q, rcving_d;
  logic             enable_timer_q, enable_timer_d;
  logic             w_enable_q, w_enable_d;
  logic             r_error_q, r_error_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             eop_sample;
  logic             room;

  assign eop_sample = eop && shift_enable;
  assign room       = byte_cnt_q < CNT_W'(MAX_BYTES);

  always_comb begin
    state_d    = state_q;
    r_error_d  = r_error_q;
    byte_cnt_d = byte_cnt_q;
    w_enable_d = 1'b0;

    case (state_q)
      IDLE, ERR_IDLE: begin
        if (d_edge) begin
          state_d    = SYNC_WAIT;
          r_error_d  = 1'b0;
          byte_cnt_d = '0;
        end
      end
      SYNC_WAIT: begin
        if (byte_received)   state_d = SYNC_CHK;
        else if (eop_sample) state_d = ERR_EOP;
      end
      SYNC_CHK: begin
        state_d = (rcv_data == SYNC_BYTE) ? RCV_BYTE : ERR_EOP;
      end
      RCV_BYTE: begin
        // A completed byte beats a coincident EOP sample; EOP_CHK catches it.
        if (byte_received) begin
          state_d    = STORE;
          w_enable_d = room;
        end else if (eop_sample) begin
          state_d = ERR_EOP;
        end
      end
      STORE: begin
        if (room) begin
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          state_d    = EOP_CHK;
        end else begin
          state_d = ERR_EOP;
        end
      end
      EOP_CHK: begin
        if (shift_enable) state_d = eop ? EOP_DONE : RCV_BYTE;
      end
      EOP_DONE: begin
        if (d_edge) state_d = IDLE;
      end
      ERR_EOP: begin
        if (eop_sample) state_d = ERR_WAIT;
      end
      ERR_WAIT: begin
        if (d_edge) state_d = ERR_IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == ERR_EOP) r_error_d = 1'b1;

    // Outputs are decoded from the next state so they register alongside it.
    rcving_d       = !(state_d inside {IDLE, ERR_IDLE});
    enable_timer_d = state_d inside {SYNC_WAIT, SYNC_CHK, RCV_BYTE, STORE,
                                     EOP_CHK, ERR_EOP};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      rcving_q       <= 1'b0;
      enable_timer_q <= 1'b0;
      w_enable_q     <= 1'b0;
      r_error_q      <= 1'b0;
      byte_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      rcving_q       <= rcving_d;
      enable_timer_q <= enable_timer_d;
      w_enable_q     <= w_enable_d;
      r_error_q      <= r_error_d;
      byte_cnt_q     <= byte_cnt_d;
    end
  end

  assign rcving       = rcving_q;
  assign enable_timer = enable_timer_q;
  assign w_enable     = w_enable_q;
  assign r_error      = r_error_q;
  assign byte_cnt     = byte_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_usb_rx_ctrl.sv
// ============================================================================
// Module   : tb_usb_rx_ctrl
// Brief    : Self-checking bench for usb_rx_ctrl; packet-level reference model,
//            one instance with default MAX_BYTES and one with MAX_BYTES=2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_rx_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_edge = 1'b0;
  logic       eop = 1'b0;
  logic       shift_enable = 1'b0;
  logic       byte_received = 1'b0;
  logic [7:0] rcv_data = 8'h00;

  logic       rcving_a, enable_timer_a, w_enable_a, r_error_a;
  logic [6:0] byte_cnt_a;
  logic       rcving_b, enable_timer_b, w_enable_b, r_error_b;
  logic [6:0] byte_cnt_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] wq_a[$];
  logic [7:0] wq_b[$];
  logic [7:0] dat[$];

  usb_rx_ctrl dut_a (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop),
    .shift_enable(shift_enable), .byte_received(byte_received),
    .rcv_data(rcv_data), .rcving(rcving_a), .enable_timer(enable_timer_a),
    .w_enable(w_enable_a), .r_error(r_error_a), .byte_cnt(byte_cnt_a)
  );

  usb_rx_ctrl #(.MAX_BYTES(2)) dut_b (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop),
    .shift_enable(shift_enable), .byte_received(byte_received),
    .rcv_data(rcv_data), .rcving(rcving_b), .enable_timer(enable_timer_b),
    .w_enable(w_enable_b), .r_error(r_error_b), .byte_cnt(byte_cnt_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (w_enable_a === 1'b1) wq_a.push_back(rcv_data);
    if (w_enable_b === 1'b1) wq_b.push_back(rcv_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit period: a shift_enable strobe followed by three quiet cycles.
  task automatic slot(input logic e, input logic dedge);
    shift_enable  = 1'b1;
    eop           = e;
    byte_received = 1'b0;
    rcv_data      = 8'($urandom);
    d_edge        = dedge;
    tick();
    shift_enable = 1'b0;
    d_edge       = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic merge,
                           input logic is_sync, input logic sync_bad);
    for (int i = 0; i < 7; i++) slot(1'b0, 1'($urandom_range(0, 1)));
    shift_enable  = 1'b1;
    eop           = merge;
    byte_received = 1'b1;
    rcv_data      = b;
    tick();
    shift_enable  = 1'b0;
    byte_received = 1'b0;
    if (is_sync) begin
      chk("sync_chk_err_a", r_error_a, 0);
      chk("sync_chk_err_b", r_error_b, 0);
    end
    tick();
    if (is_sync) begin
      chk("sync_err_a", r_error_a, sync_bad);
      chk("sync_err_b", r_error_b, sync_bad);
    end
    tick(); tick();
  endtask

  task automatic cmp_wr(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk({tag, "_data"}, got[i], exp[i]);
  endtask

  // Drive one packet (SYNC, dat[], k stray bits, EOP) and check the outcome
  // against what the packet rules predict for each instance.
  task automatic drive_packet(input logic [7:0] sync, input int k, input logic merge);
    int         n;
    logic       ok;
    logic       err_a, err_b;
    int         cnt_a, cnt_b;
    logic [7:0] ex_a[$];
    logic [7:0] ex_b[$];
    n  = dat.size();
    ok = (sync == 8'h80);
    cnt_a = ok ? ((n < 64) ? n : 64) : 0;
    cnt_b = ok ? ((n < 2) ? n : 2) : 0;
    err_a = !ok || (n == 0) || (k != 0) || (n > 64);
    err_b = !ok || (n == 0) || (k != 0) || (n > 2);
    for (int i = 0; i < cnt_a; i++) ex_a.push_back(dat[i]);
    for (int i = 0; i < cnt_b; i++) ex_b.push_back(dat[i]);
    wq_a.delete();
    wq_b.delete();

    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    chk("start_rcving", rcving_a, 1);
    chk("start_timer", enable_timer_a, 1);
    chk("start_err_a", r_error_a, 0);
    chk("start_err_b", r_error_b, 0);
    chk("start_cnt_a", byte_cnt_a, 0);
    tick(); tick();

    send_byte(sync, 1'b0, 1'b1, !ok);
    for (int i = 0; i < n; i++) send_byte(dat[i], merge && (i == n - 1), 1'b0, 1'b0);
    for (int i = 0; i < k; i++) slot(1'b0, 1'($urandom_range(0, 1)));
    if (!merge) slot(1'b1, 1'b0);
    slot(1'b1, 1'b0);
    eop = 1'b0;
    tick();
    chk("eop_rcving_a", rcving_a, 1);
    chk("eop_timer_a", enable_timer_a, 0);
    chk("eop_rcving_b", rcving_b, 1);

    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    chk("end_rcving_a", rcving_a, 0);
    chk("end_rcving_b", rcving_b, 0);
    chk("end_timer_a", enable_timer_a, 0);
    chk("end_err_a", r_error_a, err_a);
    chk("end_err_b", r_error_b, err_b);
    chk("end_cnt_a", byte_cnt_a, cnt_a);
    chk("end_cnt_b", byte_cnt_b, cnt_b);
    cmp_wr("wr_a", wq_a, ex_a);
    cmp_wr("wr_b", wq_b, ex_b);
    tick();
  endtask

  initial begin
    #3;
    chk("rst_rcving", rcving_a, 0);
    chk("rst_timer", enable_timer_a, 0);
    chk("rst_wen", w_enable_a, 0);
    chk("rst_err", r_error_a, 0);
    chk("rst_cnt", byte_cnt_a, 0);
    tick();
    n_rst = 1'b1;
    tick(); tick();

    // Good packet A5, 3C (overflows the MAX_BYTES=2 instance only at a 3rd byte).
    dat = '{8'hA5, 8'h3C};
    drive_packet(8'h80, 0, 1'b0);

    // Bad SYNC followed directly by EOP, then a good packet clears the error.
    dat.delete();
    drive_packet(8'h81, 0, 1'b0);
    dat = '{8'h11};
    drive_packet(8'h80, 0, 1'b0);

    // Early EOP after 3 bits of the first data byte.
    dat.delete();
    drive_packet(8'h80, 3, 1'b0);

    // Three bytes: clean for the default instance, overflow for MAX_BYTES=2.
    dat = '{8'h01, 8'h02, 8'h03};
    drive_packet(8'h80, 0, 1'b0);

    // Byte completion coincident with the first EOP sample.
    dat = '{8'h5A};
    drive_packet(8'h80, 0, 1'b1);

    // Asynchronous reset in the middle of the second byte.
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    send_byte(8'h80, 1'b0, 1'b1, 1'b0);
    send_byte(8'h77, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) slot(1'b0, 1'b0);
    chk("pre_rst_rcving", rcving_a, 1);
    chk("pre_rst_cnt", byte_cnt_a, 1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_rcving", rcving_a, 0);
    chk("mid_rst_timer", enable_timer_a, 0);
    chk("mid_rst_cnt", byte_cnt_a, 0);
    chk("mid_rst_err", r_error_b, 0);
    tick();
    n_rst = 1'b1;
    tick();
    dat = '{8'hC3, 8'h99};
    drive_packet(8'h80, 0, 1'b0);

    // Randomised packets.
    for (int p = 0; p < 24; p++) begin
      int         nb;
      int         kb;
      logic       mg;
      logic [7:0] sy;
      nb = $urandom_range(0, 4);
      kb = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 7);
      mg = (nb > 0) && (kb == 0) && ($urandom_range(0, 2) == 0);
      sy = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h80;
      dat.delete();
      for (int i = 0; i < nb; i++) dat.push_back(8'($urandom));
      drive_packet(sy, kb, mg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
